// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC constants and elaboration-time helpers.
//                FLIT_W    - default flit width in bits
//                BUF_DEPTH - default router input buffer depth
//                clog2()   - ceiling log2, usable in parameter expressions
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int FLIT_W    = 8;
  localparam int BUF_DEPTH = 8;

  // Smallest r with 2**r >= n. clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : noc_fifo_ram
//  Description : DEPTH x DATA_W storage array for the NoC FIFO.
//                Synchronous write port, asynchronous read port, no reset.
//  Ports       : clk      - clock, write on rising edge
//                we_i     - write enable
//                waddr_i  - write address
//                wdata_i  - write data
//                raddr_i  - read address
//                rdata_o  - read data (combinational from raddr_i)
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : noc_fifo_ram
`default_nettype wire

// File: rtl/noc_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : noc_fifo_param
//  Description : Parametrised synchronous FIFO for the router input stage.
//                Power-of-two DEPTH (>= 2), programmable almost-full /
//                almost-empty thresholds, occupancy count, sticky
//                overflow/underflow flags, standard or FWFT read mode.
//  Ports       : clk, rst (async, active-high)
//                wr_en, wr_data          - push side
//                rd_en, rd_data, rd_valid - pop side
//                full, empty, almost_full, almost_empty, count - status
//                err_clr, ovf_err, udf_err - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_fifo_param
  import noc_pkg::*;
#(
  parameter int DATA_W    = FLIT_W,
  parameter int DEPTH     = BUF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  parameter bit FWFT      = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [clog2(DEPTH+1)-1:0]   count,
  input  logic                        err_clr,
  output logic                        ovf_err,
  output logic                        udf_err
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  // Flags are decoded straight from the registered count, so they move in
  // the same cycle as count with no extra register stage.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
  assign count        = count_q;
  assign ovf_err      = ovf_q;
  assign udf_err      = udf_q;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a
  // push alongside an accepted pop. An empty FIFO never bypasses.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A new error event wins over a same-cycle clear.
  always_comb begin
    ovf_d = err_clr ? 1'b0 : ovf_q;
    udf_d = err_clr ? 1'b0 : udf_q;
    if (wr_en & ~wr_acc) ovf_d = 1'b1;
    if (rd_en & empty)   udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  noc_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented directly. It is forced to zero while empty so
      // the output is defined from reset even though the array is not.
      assign rd_data  = empty ? '0 : ram_rdata;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= ram_rdata;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule : noc_fifo_param
`default_nettype wire
